// File: rtl/cyclic_encoder_hs.sv
// cyclic_encoder_hs
// Systematic (N,K) cyclic-code encoder with valid/ready handshakes on both
// sides. A K-bit message is captured, its N-K parity bits are produced by a
// serial division LFSR (one message bit per clock, u[0] first), and the
// codeword {parity, message} is held until the consumer accepts it.
// With the defaults (N=7, K=4, G=x^3+x+1) it reproduces the legacy (7,4)
// serial encoder bit for bit.

module cyclic_encoder_hs #(
  parameter int N = 7,
  parameter int K = 4,
  parameter logic [N-K:0] G = 4'b1011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] u,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] v,
  output logic         busy
);

  // Parity width and bit-counter width. The counter is sized to hold K so it
  // can never wrap while a message is being shifted.
  localparam int R  = N - K;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;

  logic [K-1:0]   r_m;
  logic [R-1:0]   r_p;
  logic [R-1:0]   w_pNext;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_v;

  logic           w_bit;
  logic           w_fb;
  logic           w_accept;
  logic           w_lastShift;

  // A message is taken only while idle; in_valid elsewhere is ignored.
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_lastShift = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);

  assign v = r_v;

  // State register; reset wins over every handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and handshake outputs, decoded from the current state.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_stateNext = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Select the message bit addressed by the counter; the compare form keeps
  // the counter width independent of the message register width.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (r_cnt == CW'(i)) begin
        w_bit = r_m[i];
      end
    end
  end

  // One division step: the feedback is the incoming bit xor the register
  // tail, p[R-1] takes the feedback and every other stage takes its upper
  // neighbour xor the feedback gated by the matching generator coefficient.
  always_comb begin
    w_fb    = w_bit ^ r_p[0];
    w_pNext = '0;
    w_pNext[R-1] = w_fb;
    for (int i = 0; i < R - 1; i++) begin
      w_pNext[i] = (w_fb & G[R-1-i]) ^ r_p[i+1];
    end
  end

  // Message register: a private copy so the source may change u right
  // after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m <= '0;
    end else if (w_accept) begin
      r_m <= u;
    end
  end

  // Parity register: cleared on acceptance so no residue from an earlier or
  // aborted message leaks in, then advanced once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
    end else if (w_accept) begin
      r_p <= '0;
    end else if (r_state == S_SHIFT) begin
      r_p <= w_pNext;
    end
  end

  // Bit counter: walks 0..K-1 through the message during SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Codeword register: loaded with the final parity on the last shift and
  // otherwise left alone, so it stays stable through any back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else if (w_lastShift) begin
      r_v <= {w_pNext, r_m};
    end
  end

endmodule

// File: doc/cyclic_encoder_hs.md
# cyclic_encoder_hs

Parametrised systematic (N,K) cyclic-code encoder with valid/ready handshaking on both sides. It is the generalised successor of the fixed (7,4) serial LFSR encoder. Code length, message length and generator polynomial are set by parameters. It sits between a message source and the channel/modulator path. It accepts one K-bit message, computes N-K parity bits serially in an LFSR (one message bit per clock), and holds the N-bit codeword until the consumer takes it.

## Interface
- N, 7, codeword length; N > K.
- K, 4, message length; K ≥ 1.
- G, 'b1011, generator polynomial coefficients, width N-K+1; G[0] and G[N-K] must be 1. Default is x^3+x+1.
- R (localparam), N-K, parity width.

Ports (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  message u is valid.
- in_ready  output  1  encoder can accept a message.
- u  input  K  message; bit u[0] is encoded first.
- out_valid  output  1  codeword v is valid.
- out_ready  input  1  consumer accepts v.
- v  output  N  codeword {parity[R-1:0], message[K-1:0]}.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready=1; out_valid=0.
  - SHIFT: in_ready=0; out_valid=0.
  - DONE: in_ready=0; out_valid=1.
- IDLE, in_valid=1 (accept):
  - register u into message register m;
  - clear parity register p to 0;
  - clear bit counter to 0;
  - go to SHIFT.
- SHIFT, each cycle, bit b = m[cnt]:
  - f = b ^ p[0];
  - p[R-1] <= f;
  - for i = R-2 down to 0: p[i] <= (f & G[R-1-i]) ^ p[i+1];
  - cnt <= cnt+1.
- SHIFT exit: on the cycle with cnt = K-1, the update is the final one.
  - v is loaded with {p_next, m}.
  - State goes to DONE.
- Counter width is clog2(K+1); it never wraps within a message.
- DONE: v and out_valid are held stable until out_ready=1. On out_ready=1, go to IDLE the next cycle.
- Once accepted, u may change freely; the encoder uses only its registered copy m.
- in_valid during SHIFT/DONE is ignored (in_ready=0). No message is queued.
- v retains its last codeword in IDLE/SHIFT. It is meaningful only while out_valid=1.
- rst:
  - state returns to IDLE;
  - p, m, cnt and v clear to 0;
  - in_ready=1, out_valid=0, busy=0.
- rst asserted mid-SHIFT or in DONE aborts the message. No codeword is emitted for it.
- Equivalence: with N=7, K=4, G='b1011, codewords match the legacy (7,4) encoder bit-for-bit.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, v=0.
- Acceptance edge = T (rising edge where in_valid & in_ready). in_ready falls after T.
- SHIFT occupies edges T+1 … T+K.
- out_valid rises after edge T+K, i.e. K cycles after acceptance.
- If out_ready is already high, the codeword is taken at edge T+K+1. in_ready is high after T+K+1, and the next message can be accepted at edge T+K+2.
- Maximum throughput: one codeword per K+2 cycles.
- Back-pressure: out_valid stays high and v stays unchanged for any number of cycles with out_ready=0.
- rst has priority over all handshakes on the same edge.

## Test plan
- Defaults, u=4'b0001 accepted at edge T:
  - v=7'b1010001;
  - out_valid high exactly 4 cycles after T;
  - in_ready low meanwhile.
- Defaults, u=4'b1111 → v=7'b1111111. u=4'b0000 → v=7'b0000000.
- Exhaustive over all 16 messages, compared against a reference model (polynomial division).
- Back-pressure: hold out_ready=0 for 10 cycles in DONE:
  - v and out_valid stay constant;
  - a new in_valid is ignored;
  - after out_ready=1, in_ready returns the next cycle.
- Reset mid-SHIFT (after 2 shifts):
  - next cycle state is IDLE, in_ready=1, out_valid=0, v=0;
  - a following message encodes correctly with no residue in p.
- Reparametrised N=15, K=11, G='b10011: all-ones message → all-ones codeword; 200 random messages match the model; latency is 11 cycles.
